// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipe: load-use, branch flush, memory wait.
// Optional PIPE_PERF_CNT_EN enables the saturating stall-cycle counter.
module pipe_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 16
) (
  input  logic             clk_i,
  input  logic             start_i,
  input  logic             IDEX_MemRead_i,
  input  logic [4:0]       IDEX_RDaddr_i,
  input  logic [4:0]       IFID_RSaddr_i,
  input  logic [4:0]       IFID_RTaddr_i,
  input  logic             Branch_taken_i,
  input  logic             MemReq_i,
  input  logic             MemAck_i,
  output logic             PCWrite_o,
  output logic             IFID_Write_o,
  output logic             IFID_Flush_o,
  output logic             IDEX_Write_o,
  output logic             IDEX_Bubble_o,
  output logic             EXMEM_Write_o,
  output logic             MEMWB_Bubble_o,
  output logic [1:0]       state_o,
  output logic             err_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  localparam int WW = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    MWAIT = 2'd2,
    ERR   = 2'd3
  } state_t;

  state_t        state;
  logic [WW-1:0] wcnt;
  logic          err;
  logic          active;
  logic          mem_stall;
  logic          load_use;

  always_comb begin
    active    = (state == RUN) || (state == MWAIT);
    mem_stall = ((state == RUN) && MemReq_i && !MemAck_i)
              || ((state == MWAIT) && !MemAck_i);
    load_use  = IDEX_MemRead_i
              && (IDEX_RDaddr_i != 5'd0)
              && ((IDEX_RDaddr_i == IFID_RSaddr_i)
                  || (IDEX_RDaddr_i == IFID_RTaddr_i));
  end

  always_comb begin
    PCWrite_o      = 1'b1;
    IFID_Write_o   = 1'b1;
    IFID_Flush_o   = 1'b0;
    IDEX_Write_o   = 1'b1;
    IDEX_Bubble_o  = 1'b0;
    EXMEM_Write_o  = 1'b1;
    MEMWB_Bubble_o = 1'b0;
    priority case (1'b1)
      !active: begin
        PCWrite_o      = 1'b0;
        IFID_Write_o   = 1'b0;
        IDEX_Write_o   = 1'b0;
        IDEX_Bubble_o  = 1'b1;
        EXMEM_Write_o  = 1'b0;
        MEMWB_Bubble_o = 1'b1;
      end
      mem_stall: begin
        PCWrite_o      = 1'b0;
        IFID_Write_o   = 1'b0;
        IDEX_Write_o   = 1'b0;
        EXMEM_Write_o  = 1'b0;
        MEMWB_Bubble_o = 1'b1;
      end
      load_use: begin
        PCWrite_o     = 1'b0;
        IFID_Write_o  = 1'b0;
        IDEX_Bubble_o = 1'b1;
      end
      Branch_taken_i: IFID_Flush_o = 1'b1;
      default: ;
    endcase
  end

  // Counter holds the number of stall cycles of the current access.
  always_ff @(posedge clk_i or negedge start_i) begin
    if (!start_i) begin
      state <= IDLE;
      wcnt  <= '0;
      err   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: state <= RUN;
        RUN: begin
          if (MemReq_i && !MemAck_i) begin
            state <= MWAIT;
            wcnt  <= WW'(1);
          end
        end
        MWAIT: begin
          if (MemAck_i) begin
            state <= RUN;
            wcnt  <= '0;
          end else if (wcnt == WW'(MEM_TIMEOUT)) begin
            state <= ERR;
            err   <= 1'b1;
          end else begin
            wcnt <= wcnt + WW'(1);
          end
        end
        ERR: state <= ERR;
        default: state <= IDLE;
      endcase
    end
  end

  assign state_o = state;
  assign err_o   = err;

`ifdef PIPE_PERF_CNT_EN
  logic [CNT_W-1:0] scnt;

  always_ff @(posedge clk_i or negedge start_i) begin
    if (!start_i) begin
      scnt <= '0;
    end else if (active && !PCWrite_o && (scnt != {CNT_W{1'b1}})) begin
      scnt <= scnt + CNT_W'(1);
    end
  end

  assign stall_cnt_o = scnt;
`else
  assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed vector table, hand sequences, random vs model.
// Expects the stall counter only when PIPE_PERF_CNT_EN is defined.
module tb_pipe_hazard_ctrl;

  localparam int TO = 4;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          start;
  logic          mr;
  logic [4:0]    rd;
  logic [4:0]    rs;
  logic [4:0]    rt;
  logic          br;
  logic          req;
  logic          ack;
  logic          pcw;
  logic          ifidw;
  logic          flush;
  logic          idexw;
  logic          idexb;
  logic          exmemw;
  logic          memwbb;
  logic [1:0]    st;
  logic          err;
  logic [CW-1:0] scnt;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(
    .MEM_TIMEOUT(TO),
    .CNT_W      (CW)
  ) dut (
    .clk_i         (clk),
    .start_i       (start),
    .IDEX_MemRead_i(mr),
    .IDEX_RDaddr_i (rd),
    .IFID_RSaddr_i (rs),
    .IFID_RTaddr_i (rt),
    .Branch_taken_i(br),
    .MemReq_i      (req),
    .MemAck_i      (ack),
    .PCWrite_o     (pcw),
    .IFID_Write_o  (ifidw),
    .IFID_Flush_o  (flush),
    .IDEX_Write_o  (idexw),
    .IDEX_Bubble_o (idexb),
    .EXMEM_Write_o (exmemw),
    .MEMWB_Bubble_o(memwbb),
    .state_o       (st),
    .err_o         (err),
    .stall_cnt_o   (scnt)
  );

  typedef struct packed {
    logic       mr;
    logic [4:0] rd;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       br;
    logic       req;
    logic       ack;
  } in_t;

  typedef struct packed {
    in_t        i;
    logic [6:0] ctrl;
    logic [1:0] st;
  } vec_t;

  int nvec = 0;
  int nerr = 0;

  // Reference: 0 idle, 1 run, 2 waiting on memory, 3 error.
  int m_mode;
  int m_mw;
  int m_cnt;
  bit m_err;

  function automatic in_t mk(logic m, int d, int s, int t,
                             logic b, logic q, logic a);
    in_t v;
    v.mr  = m;
    v.rd  = 5'(d);
    v.rs  = 5'(s);
    v.rt  = 5'(t);
    v.br  = b;
    v.req = q;
    v.ack = a;
    return v;
  endfunction

  // Control bits: pcw ifidw flush idexw idexb exmemw memwbb.
  // hold = number of leading pipe registers held this cycle.
  function automatic logic [6:0] model_ctrl(in_t v);
    int hold;
    bit halted;
    halted = (m_mode == 0) || (m_mode == 3);
    if (halted)
      hold = 4;
    else if ((m_mode == 1 && v.req && !v.ack) || (m_mode == 2 && !v.ack))
      hold = 4;
    else if (v.mr && v.rd != 0 && (v.rd == v.rs || v.rd == v.rt))
      hold = 2;
    else
      hold = 0;
    return {hold < 1, hold < 2, v.br && hold == 0 && !halted,
            hold < 3, halted || hold == 2, hold < 4, hold == 4};
  endfunction

  function automatic void model_reset();
    m_mode = 0;
    m_mw   = 0;
    m_cnt  = 0;
    m_err  = 0;
  endfunction

  function automatic void model_step(in_t v, logic [6:0] c);
    if ((m_mode == 1 || m_mode == 2) && !c[6] && m_cnt < (1 << CW) - 1)
      m_cnt++;
    case (m_mode)
      0: m_mode = 1;
      1: if (v.req && !v.ack) begin
        m_mode = 2;
        m_mw   = 0;
      end
      2: if (v.ack) begin
        m_mode = 1;
      end else begin
        m_mw++;
        if (m_mw == TO) begin
          m_mode = 3;
          m_err  = 1;
        end
      end
      default: ;
    endcase
  endfunction

  function automatic logic [25:0] exp_all(in_t v);
    logic [CW-1:0] c;
`ifdef PIPE_PERF_CNT_EN
    c = CW'(m_cnt);
`else
    c = '0;
`endif
    return {model_ctrl(v), 2'(m_mode), m_err, c};
  endfunction

  function automatic logic [25:0] dut_all();
    return {pcw, ifidw, flush, idexw, idexb, exmemw, memwbb, st, err, scnt};
  endfunction

  task automatic check(string name, logic [25:0] act, logic [25:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(in_t v);
    mr  = v.mr;
    rd  = v.rd;
    rs  = v.rs;
    rt  = v.rt;
    br  = v.br;
    req = v.req;
    ack = v.ack;
  endtask

  // Entered 1 or 2 time units after a rising edge; leaves 1 after the next.
  task automatic step(string name, in_t v);
    logic [6:0] c;
    drive(v);
    #3;
    check(name, dut_all(), exp_all(v));
    c = model_ctrl(v);
    @(posedge clk);
    model_step(v, c);
    #1;
  endtask

  task automatic do_reset();
    start = 1'b0;
    #1;
    model_reset();
    check("reset_pulse", dut_all(), {7'b0000101, 2'd0, 1'b0, 16'd0});
    start = 1'b1;
  endtask

  vec_t tbl[18];
  in_t  zero;
  in_t  v;

  initial begin
    zero = mk(0, 0, 0, 0, 0, 0, 0);
    tbl[0]  = {zero,                           7'b0000101, 2'd0};
    tbl[1]  = {zero,                           7'b1101010, 2'd1};
    tbl[2]  = {mk(1, 5, 0, 5, 0, 0, 0),        7'b0001110, 2'd1};
    tbl[3]  = {mk(1, 0, 0, 0, 0, 0, 0),        7'b1101010, 2'd1};
    tbl[4]  = {mk(1, 7, 7, 3, 0, 0, 0),        7'b0001110, 2'd1};
    tbl[5]  = {mk(0, 7, 7, 3, 0, 0, 0),        7'b1101010, 2'd1};
    tbl[6]  = {mk(1, 9, 9, 1, 1, 0, 0),        7'b0001110, 2'd1};
    tbl[7]  = {mk(0, 0, 0, 0, 1, 0, 0),        7'b1111010, 2'd1};
    tbl[8]  = {mk(0, 0, 0, 0, 0, 1, 1),        7'b1101010, 2'd1};
    tbl[9]  = {mk(0, 0, 0, 0, 1, 1, 0),        7'b0000001, 2'd1};
    tbl[10] = {mk(0, 0, 0, 0, 0, 1, 0),        7'b0000001, 2'd2};
    tbl[11] = {mk(0, 0, 0, 0, 0, 1, 0),        7'b0000001, 2'd2};
    tbl[12] = {mk(0, 0, 0, 0, 1, 1, 1),        7'b1111010, 2'd2};
    tbl[13] = {zero,                           7'b1101010, 2'd1};
    tbl[14] = {mk(1, 31, 31, 31, 0, 0, 0),     7'b0001110, 2'd1};
    tbl[15] = {mk(1, 2, 2, 0, 0, 1, 0),        7'b0000001, 2'd1};
    tbl[16] = {mk(1, 2, 2, 0, 0, 0, 1),        7'b0001110, 2'd2};
    tbl[17] = {zero,                           7'b1101010, 2'd1};

    start = 1'b0;
    drive(zero);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset", dut_all(), {7'b0000101, 2'd0, 1'b0, 16'd0});
    start = 1'b1;

    for (int k = 0; k < 18; k++) begin
      drive(tbl[k].i);
      #3;
      check($sformatf("tbl%0d", k),
            {pcw, ifidw, flush, idexw, idexb, exmemw, memwbb, st, 17'd0},
            {tbl[k].ctrl, tbl[k].st, 17'd0});
      #0;
      begin
        logic [6:0] c;
        check($sformatf("tbl%0d_model", k), dut_all(), exp_all(tbl[k].i));
        c = model_ctrl(tbl[k].i);
        @(posedge clk);
        model_step(tbl[k].i, c);
        #1;
      end
    end

    // Memory timeout, then ack must not leave the error state.
    do_reset();
    step("to_idle", zero);
    step("to_run", mk(0, 0, 0, 0, 0, 1, 0));
    for (int k = 0; k < TO; k++)
      step($sformatf("to_wait%0d", k), mk(0, 0, 0, 0, 0, 1, 0));
    check("timeout_err", {st, err, 23'd0}, {2'd3, 1'b1, 23'd0});
    for (int k = 0; k < 3; k++)
      step($sformatf("err_ack%0d", k), mk(0, 0, 0, 0, 1, 1, 1));
    check("err_sticky", {st, err, pcw, memwbb, 21'd0},
          {2'd3, 1'b1, 1'b0, 1'b1, 21'd0});
    do_reset();

    // Three-cycle memory wait and stall count.
    step("mw_idle", zero);
    for (int k = 0; k < 3; k++)
      step($sformatf("mw_wait%0d", k), mk(0, 0, 0, 0, 0, 1, 0));
    step("mw_ack", mk(0, 0, 0, 0, 0, 1, 1));
`ifdef PIPE_PERF_CNT_EN
    check("mw_stall_cnt", {10'd0, scnt}, {10'd0, 16'd3});
`endif
    check("mw_back_run", {st, pcw, 23'd0}, {2'd1, 1'b1, 23'd0});

    // Reset pulse in the middle of a memory wait.
    step("mid_run", mk(0, 0, 0, 0, 0, 1, 0));
    step("mid_wait", mk(0, 0, 0, 0, 0, 1, 0));
    do_reset();

    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 31) == 0)
        do_reset();
      v = mk($urandom_range(0, 1), $urandom_range(0, 3),
             $urandom_range(0, 3), $urandom_range(0, 3),
             $urandom_range(0, 1), $urandom_range(0, 1),
             $urandom_range(0, 1));
      step("rand", v);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage pipeline.
- Drives write-enable, bubble and flush controls of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers.
- Decisions come from load-use hazards, taken branches resolved in ID, and multi-cycle data-memory accesses in MEM.
- Small FSM tracks memory wait and timeout; an error state freezes the pipe.

Parameters:
- MEM_TIMEOUT, 64, max MWAIT cycles before entering ERR (legal range 2..65535).
- CNT_W, 16, width of the stall performance counter.

Ports:
- clk_i  input  1  clock, rising edge.
- start_i  input  1  reset, asynchronous, active-low.
- IDEX_MemRead_i  input  1  instruction in EX is a load.
- IDEX_RDaddr_i  input  5  destination register of instruction in EX.
- IFID_RSaddr_i  input  5  rs of instruction in ID.
- IFID_RTaddr_i  input  5  rt of instruction in ID.
- Branch_taken_i  input  1  branch in ID resolved taken.
- MemReq_i  input  1  instruction in MEM accesses data memory.
- MemAck_i  input  1  data memory completes access this cycle.
- PCWrite_o  output  1  PC update enable.
- IFID_Write_o  output  1  IF/ID enable.
- IFID_Flush_o  output  1  IF/ID clear to NOP.
- IDEX_Write_o  output  1  ID/EX enable.
- IDEX_Bubble_o  output  1  load NOP controls into ID/EX.
- EXMEM_Write_o  output  1  EX/MEM enable.
- MEMWB_Bubble_o  output  1  load RegWrite=0, MemtoReg=0 into MEM/WB.
- state_o  output  2  FSM state: 0 IDLE, 1 RUN, 2 MWAIT, 3 ERR.
- err_o  output  1  sticky memory-timeout flag.
- stall_cnt_o  output  CNT_W  stall cycle counter.

Behaviour:
- Reset (start_i=0, asynchronous):
  - state=IDLE, err_o=0, wait counter=0, stall_cnt_o=0.
- Control outputs are combinational from state and inputs.
- IDLE:
  - All enables 0; IDEX_Bubble_o=1, MEMWB_Bubble_o=1, IFID_Flush_o=0.
  - Always moves to RUN on the next edge (one-cycle pipe settle after reset release).
- RUN, default: all enables 1, bubbles/flush 0.
- RUN, priority 1, memory stall (MemReq_i=1, MemAck_i=0):
  - PCWrite, IFID_Write, IDEX_Write, EXMEM_Write = 0.
  - MEMWB_Bubble_o=1, so WB does not write twice.
  - Next state MWAIT, wait counter=1.
- RUN, MemReq_i=1 with MemAck_i=1: zero-wait access, no stall.
- RUN, priority 2, load-use hazard:
  - Condition: IDEX_MemRead_i=1, IDEX_RDaddr_i!=0, and IDEX_RDaddr_i equals IFID_RSaddr_i or IFID_RTaddr_i.
  - PCWrite_o=0, IFID_Write_o=0, IDEX_Bubble_o=1; others default.
- RUN, priority 3, taken branch: Branch_taken_i=1 gives IFID_Flush_o=1.
  - Suppressed when a load-use or memory stall is active that cycle; the branch re-resolves next cycle.
- MWAIT without MemAck_i:
  - Same freeze as a memory stall.
  - Wait counter increments.
  - When the counter equals MEM_TIMEOUT: next state ERR, err_o=1.
- MWAIT with MemAck_i=1:
  - Freeze released that same cycle; outputs follow RUN priorities 2/3.
  - Next state RUN, wait counter cleared.
- ERR:
  - All enables 0, MEMWB_Bubble_o=1, IDEX_Bubble_o=1.
  - Exits only via reset; MemAck_i ignored.
- Wait counter: width ceil(log2(MEM_TIMEOUT+1)), never wraps.
- Reset asserted mid-MWAIT: immediate return to IDLE, no timeout flagged.

Optional Feature:
- Macro PIPE_PERF_CNT_EN.
- Defined:
  - stall_cnt_o increments on every cycle in RUN or MWAIT where PCWrite_o=0.
  - Saturates at all-ones; does not wrap.
  - Cleared only by reset.
- Undefined: counter logic absent; stall_cnt_o tied to 0.

Test Plan:
- Release reset -> IDLE one cycle (all enables 0, both bubbles 1), then RUN with all enables 1, state_o=1.
- IDEX_MemRead_i=1, IDEX_RDaddr_i=5, IFID_RTaddr_i=5 -> PCWrite_o=0, IFID_Write_o=0, IDEX_Bubble_o=1 for that cycle; same with RDaddr=0 -> no stall.
- MemReq_i=1, MemAck_i low 3 cycles then high -> MWAIT for 3 cycles with freeze and MEMWB_Bubble_o=1. Ack cycle enables=1, then RUN. With PIPE_PERF_CNT_EN, stall_cnt_o=3.
- MEM_TIMEOUT=4, MemReq_i=1, MemAck_i never -> after the 4th wait cycle state_o=3, err_o=1; later MemAck_i=1 keeps ERR until start_i=0.
- Branch_taken_i=1 together with load-use hazard -> IFID_Flush_o=0 and stall; next cycle hazard gone and branch taken -> IFID_Flush_o=1.
- start_i pulsed low during MWAIT -> outputs immediately at IDLE values, err_o=0, stall_cnt_o=0.
